banked_mem_arbiter: RTL and testbench
=====================================

// Module: banked_mem_arbiter
// PURPOSE
//  N-port, M-bank word-interleaved SRAM subsystem with OBI-style req/gnt/rvalid ports.
//  Replaces fixed dual-port wrappers: arbitrates bank conflicts per bank (round-robin stall, no error).
//  Checks the address map and returns fixed-latency responses per port.
//  Sits between Vicuna core/vector LSU ports and on-chip data memory.
// PARAMETERS
//  NUM_PORTS   2         requester ports (1..8)
//  NUM_BANKS   4         banks, power of 2 (1..16); consecutive words go to consecutive banks
//  DATA_WIDTH  32        word width, multiple of 8
//  ADDR_WIDTH  32        byte address width
//  BANK_DEPTH  512       words per bank, power of 2
//  OUT_REG     0         1 = extra output register stage on rdata/rvalid/err
//  BASE_ADDR   '0        [ADDR_WIDTH] base of mapped region, aligned to total size
// PORTS
//  clk         in   1                      clock, all logic posedge
//  rst         in   1                      reset, asynchronous, active-low
//  req         in   [NUM_PORTS]            request valid, held until gnt
//  addr        in   [NUM_PORTS][ADDR_WIDTH]   byte address
//  we          in   [NUM_PORTS]            1 = write
//  be          in   [NUM_PORTS][DATA_WIDTH/8] byte enables
//  wdata       in   [NUM_PORTS][DATA_WIDTH]   write data
//  gnt         out  [NUM_PORTS]            request accepted this cycle (combinational)
//  rvalid      out  [NUM_PORTS]            response valid
//  err         out  [NUM_PORTS]            response error, qualified by rvalid
//  rdata       out  [NUM_PORTS][DATA_WIDTH]   read data, qualified by rvalid
// BEHAVIOUR
//  Address decode: OFF=clog2(DATA_WIDTH/8), BB=clog2(NUM_BANKS), RB=clog2(BANK_DEPTH).
//   bank=addr[OFF+BB-1:OFF]; row=addr[OFF+BB+RB-1:OFF+BB].
//   Tag=addr[ADDR_WIDTH-1:OFF+BB+RB] must equal the same BASE_ADDR bits; otherwise the request is unmapped.
//  Unmapped request:
//   - granted the same cycle with no arbitration and no bank access; a write is dropped.
//   - response: err=1, rdata=0.
//  Arbitration, per bank, among mapped requesting ports:
//   - round-robin; winner gets gnt in the same cycle; losers see gnt=0 and must hold.
//   - pointer[bank] moves to winner+1 mod NUM_PORTS on each grant; unchanged when idle.
//   - no combinational path from gnt to req.
//  Bank access: 1RW inferred array; one access per bank per cycle.
//   - write: only bytes with be=1 updated; be=0 write still responds.
//   - read: data valid the cycle after grant.
//  Latency: grant at cycle N -> rvalid at N+1+OUT_REG, exactly one rvalid per gnt.
//   - responses per port are in order; any per-cycle throughput of 1 per port.
//  Write response: rvalid=1, err=0, rdata=0.
//  Ordering:
//   - write granted at N, read of same word granted at N+1 (any port) -> returns new data.
//   - same-cycle same-word access by two ports is impossible (same bank is serialised).
//  Reset (rst=0, async):
//   - gnt=0, rvalid=0, err=0, rdata=0; all pointers=0; in-flight responses discarded.
//   - memory contents are not reset and are undefined after power-up.
//   - first grant possible in the first posedge after rst deasserts.
//  Outputs rvalid/err/rdata are registered; gnt is combinational from req/addr/pointers only.
// TESTING
//  1 Write 0xDEADBEEF to 0x0 (port0, be=1111); read 0x0 next cycle -> rvalid at N+1, rdata=0xDEADBEEF, err=0.
//  2 Both ports req bank0 (0x0, 0x10) continuously for 4 cycles -> grants alternate p0,p1,p0,p1; no err.
//  3 Ports hit different banks (0x0, 0x4) same cycle -> both gnt same cycle, both rvalid at N+1.
//  4 be=0010 write 0x0000AB00 over 0x11223344 -> read 0x1122AB44.
//  5 Access addr=BASE_ADDR+total_size -> gnt same cycle; rvalid with err=1, rdata=0; memory unchanged.
//  6 Assert rst with reads in flight (OUT_REG=1) -> rvalid=0 immediately; no stale rvalid after release.

Source files
------------

// File: rtl/banked_mem_arbiter.sv
// banked_mem_arbiter
//   Word-interleaved, multi-bank on-chip data memory shared by NUM_PORTS
//   OBI-style requesters. Each bank has its own round-robin arbiter, so
//   requests that hit different banks proceed in parallel while same-bank
//   requests are serialised; losers are stalled by gnt=0 and no error is
//   raised. Requests outside the mapped window are granted immediately and
//   answered with err=1. Every grant produces exactly one response
//   1+OUT_REG cycles later, so responses on a port stay in order.
//
// Ports
//   clk       in   clock, all logic on posedge
//   rst       in   asynchronous reset, active-low
//   req_i     in   [NUM_PORTS]                 request valid, held until gnt
//   addr_i    in   [NUM_PORTS][ADDR_WIDTH]     byte address
//   we_i      in   [NUM_PORTS]                 1 = write
//   be_i      in   [NUM_PORTS][DATA_WIDTH/8]   byte enables
//   wdata_i   in   [NUM_PORTS][DATA_WIDTH]     write data
//   gnt_o     out  [NUM_PORTS]                 request accepted this cycle (combinational)
//   rvalid_o  out  [NUM_PORTS]                 response valid
//   err_o     out  [NUM_PORTS]                 response error, qualified by rvalid
//   rdata_o   out  [NUM_PORTS][DATA_WIDTH]     read data, qualified by rvalid
module banked_mem_arbiter #(
  parameter int                    NUM_PORTS  = 2,
  parameter int                    NUM_BANKS  = 4,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    BANK_DEPTH = 512,
  parameter int                    OUT_REG    = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_PORTS-1:0]                   req_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS-1:0]                   we_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]                   gnt_o,
  output logic [NUM_PORTS-1:0]                   rvalid_o,
  output logic [NUM_PORTS-1:0]                   err_o,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   rdata_o
);

  localparam int NBE     = DATA_WIDTH / 8;
  localparam int OFF     = $clog2(NBE);
  localparam int BB      = $clog2(NUM_BANKS);
  localparam int RB      = $clog2(BANK_DEPTH);
  localparam int TAG_LSB = OFF + BB + RB;
  localparam int BW      = (NUM_BANKS > 1) ? BB : 1;
  localparam int RW      = (BANK_DEPTH > 1) ? RB : 1;
  localparam int PW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Per-port address decode
  logic [NUM_PORTS-1:0][BW-1:0]             port_bank_s;
  logic [NUM_PORTS-1:0][RW-1:0]             port_row_s;
  logic [NUM_PORTS-1:0]                     mapped_s;

  // Per-bank arbitration and access
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0]      cand_s;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0][PW-1:0] rr_idx_s;
  logic [NUM_BANKS-1:0]                     bank_vld_s;
  logic [NUM_BANKS-1:0][PW-1:0]             bank_win_s;
  logic [NUM_BANKS-1:0]                     bank_en_s;
  logic [NUM_BANKS-1:0]                     bank_we_s;
  logic [NUM_BANKS-1:0][RW-1:0]             bank_row_s;
  logic [NUM_BANKS-1:0][NBE-1:0]            bank_be_s;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]     bank_wdata_s;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]     bank_rdata_s;
  logic [NUM_BANKS-1:0][PW-1:0]             ptr_q, ptr_d;

  logic [NUM_PORTS-1:0]                     gnt_s;

  // First response stage: remembers what each grant must answer with
  logic [NUM_PORTS-1:0]                     rsp_vld_q, rsp_vld_d;
  logic [NUM_PORTS-1:0]                     rsp_err_q, rsp_err_d;
  logic [NUM_PORTS-1:0]                     rsp_rd_q,  rsp_rd_d;
  logic [NUM_PORTS-1:0][BW-1:0]             rsp_bank_q, rsp_bank_d;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     rsp_rdata_s;

  // Decode bank, row and map hit; the tag compare works on shifted values so
  // it degenerates cleanly when the banks cover the whole address space.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_bank_s[p] = (NUM_BANKS > 1) ? BW'(addr_i[p] >> OFF) : {BW{1'b0}};
      port_row_s[p]  = (BANK_DEPTH > 1) ? RW'(addr_i[p] >> (OFF + BB)) : {RW{1'b0}};
      mapped_s[p]    = ((addr_i[p] >> TAG_LSB) == (BASE_ADDR >> TAG_LSB));
    end
  end

  // Round-robin per bank: scan from the pointer; iterating the search
  // backwards lets the lowest distance from the pointer overwrite last.
  always_comb begin
    cand_s     = '0;
    rr_idx_s   = '0;
    bank_vld_s = '0;
    bank_win_s = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        cand_s[b][p] = req_i[p] & mapped_s[p] & (port_bank_s[p] == BW'(b));
      end
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        rr_idx_s[b][k] = PW'((int'(ptr_q[b]) + k) % NUM_PORTS);
        bank_win_s[b]  = cand_s[b][rr_idx_s[b][k]] ? rr_idx_s[b][k] : bank_win_s[b];
        bank_vld_s[b]  = bank_vld_s[b] | cand_s[b][rr_idx_s[b][k]];
      end
    end
  end

  // Grants: unmapped requests bypass arbitration; nothing is granted in reset
  always_comb begin
    gnt_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      gnt_s[p] = rst & req_i[p] &
                 (~mapped_s[p] |
                  (bank_vld_s[port_bank_s[p]] & (bank_win_s[port_bank_s[p]] == PW'(p))));
    end
  end

  assign gnt_o = gnt_s;

  // Route each bank's winning request to the bank and advance its pointer
  always_comb begin
    bank_en_s    = '0;
    bank_we_s    = '0;
    bank_row_s   = '0;
    bank_be_s    = '0;
    bank_wdata_s = '0;
    ptr_d        = ptr_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_en_s[b]    = rst & bank_vld_s[b];
      bank_we_s[b]    = we_i[bank_win_s[b]];
      bank_row_s[b]   = port_row_s[bank_win_s[b]];
      bank_be_s[b]    = be_i[bank_win_s[b]];
      bank_wdata_s[b] = wdata_i[bank_win_s[b]];
      if (bank_en_s[b]) begin
        ptr_d[b] = (bank_win_s[b] == PW'(NUM_PORTS - 1)) ? {PW{1'b0}}
                                                          : bank_win_s[b] + PW'(1'b1);
      end else begin
        ptr_d[b] = ptr_q[b];
      end
    end
  end

  // Round-robin pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem_q [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // Single-port bank: byte-masked write or registered read, never both
    always_ff @(posedge clk) begin
      if (bank_en_s[b]) begin
        if (bank_we_s[b]) begin
          for (int i = 0; i < NBE; i++) begin
            if (bank_be_s[b][i]) begin
              mem_q[bank_row_s[b]][i*8 +: 8] <= bank_wdata_s[b][i*8 +: 8];
            end
          end
        end else begin
          rd_q <= mem_q[bank_row_s[b]];
        end
      end
    end

    assign bank_rdata_s[b] = rd_q;
  end

  // Classify each grant for its response: error, read data or plain ack
  always_comb begin
    rsp_vld_d  = gnt_s;
    rsp_err_d  = gnt_s & ~mapped_s;
    rsp_rd_d   = gnt_s & mapped_s & ~we_i;
    rsp_bank_d = port_bank_s;
  end

  // First response stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_vld_q  <= '0;
      rsp_err_q  <= '0;
      rsp_rd_q   <= '0;
      rsp_bank_q <= '0;
    end else begin
      rsp_vld_q  <= rsp_vld_d;
      rsp_err_q  <= rsp_err_d;
      rsp_rd_q   <= rsp_rd_d;
      rsp_bank_q <= rsp_bank_d;
    end
  end

  // Read data comes from the bank's read register; writes and errors give zero
  always_comb begin
    rsp_rdata_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rsp_rdata_s[p] = rsp_rd_q[p] ? bank_rdata_s[rsp_bank_q[p]] : {DATA_WIDTH{1'b0}};
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [NUM_PORTS-1:0]                 out_vld_q;
    logic [NUM_PORTS-1:0]                 out_err_q;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] out_rdata_q;

    // Optional retiming stage on the response outputs
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        out_vld_q   <= '0;
        out_err_q   <= '0;
        out_rdata_q <= '0;
      end else begin
        out_vld_q   <= rsp_vld_q;
        out_err_q   <= rsp_err_q;
        out_rdata_q <= rsp_rdata_s;
      end
    end

    assign rvalid_o = out_vld_q;
    assign err_o    = out_err_q;
    assign rdata_o  = out_rdata_q;
  end else begin : g_no_out_reg
    assign rvalid_o = rsp_vld_q;
    assign err_o    = rsp_err_q;
    assign rdata_o  = rsp_rdata_s;
  end

endmodule

// File: tb/tb_banked_mem_arbiter.sv
// Directed bench for banked_mem_arbiter. Two instances (OUT_REG=0 and
// OUT_REG=1) share the same stimulus; a per-cycle reference model derives
// grants and responses from the address map and round-robin rules, and
// the stimulus additionally pins selected grants/responses to literal values.
module tb_banked_mem_arbiter;

  localparam int NP = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  typedef struct {
    logic        v;
    logic        e;
    logic [31:0] d;
    logic        k;
    logic        le;
    logic        lerr;
    logic [31:0] ld;
  } resp_t;

  logic                    clk;
  logic                    rst;
  logic [NP-1:0]           req;
  logic [NP-1:0][AW-1:0]   addr;
  logic [NP-1:0]           we;
  logic [NP-1:0][3:0]      be;
  logic [NP-1:0][DW-1:0]   wdata;
  logic [NP-1:0]           gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [NP-1:0][DW-1:0]   rdata0, rdata1;

  // literal expectations attached by the stimulus to the current cycle
  logic          lit_gnt_en;
  logic [NP-1:0] lit_gnt;
  logic [NP-1:0] lit_en;
  logic [NP-1:0] lit_err;
  logic [31:0]   lit_data [NP];

  // model state, owned by the compare process
  logic [31:0] mm [int];
  int          ptr [4];
  resp_t       pa [NP];
  resp_t       pb [NP];
  resp_t       nr [NP];
  logic [NP-1:0] eg;
  int          n_vec;
  int          n_mis;

  banked_mem_arbiter #(.OUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt0), .rvalid_o(rvalid0), .err_o(err0), .rdata_o(rdata0)
  );

  banked_mem_arbiter #(.OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rvalid1), .err_o(err1), .rdata_o(rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_mapped(input logic [31:0] a);
    return (a >> 13) == 32'd0;
  endfunction

  function automatic int bank_of(input logic [31:0] a);
    return int'((a >> 2) & 32'd3);
  endfunction

  function automatic int key_of(input logic [31:0] a);
    return int'((a >> 2) & 32'h7ff);
  endfunction

  // Compare process: checks outputs then advances the model by one cycle
  always @(negedge clk) begin
    if (!rst) begin
      chk("reset gnt0", 64'(gnt0), 64'd0);
      chk("reset gnt1", 64'(gnt1), 64'd0);
      chk("reset rvalid0", 64'(rvalid0), 64'd0);
      chk("reset rvalid1", 64'(rvalid1), 64'd0);
      chk("reset err", 64'({err1, err0}), 64'd0);
      chk("reset rdata0", 64'(rdata0), 64'd0);
      chk("reset rdata1", 64'(rdata1), 64'd0);
      for (int b = 0; b < 4; b++) ptr[b] = 0;
      for (int p = 0; p < NP; p++) begin
        pa[p] = '{default: 1'b0, d: 32'd0, ld: 32'd0};
        pb[p] = '{default: 1'b0, d: 32'd0, ld: 32'd0};
      end
    end else begin
      // expected grants
      eg = '0;
      for (int p = 0; p < NP; p++) begin
        if (req[p] && !is_mapped(addr[p])) eg[p] = 1'b1;
      end
      for (int b = 0; b < 4; b++) begin
        for (int k = 0; k < NP; k++) begin
          int q;
          q = (ptr[b] + k) % NP;
          if (req[q] && is_mapped(addr[q]) && bank_of(addr[q]) == b) begin
            eg[q] = 1'b1;
            ptr[b] = (q + 1) % NP;
            break;
          end
        end
      end
      chk("gnt dut0", 64'(gnt0), 64'(eg));
      chk("gnt dut1", 64'(gnt1), 64'(eg));
      if (lit_gnt_en) chk("gnt literal", 64'(gnt0), 64'(lit_gnt));

      // responses due this cycle
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("rvalid0 p%0d", p), 64'(rvalid0[p]), 64'(pa[p].v));
        chk($sformatf("rvalid1 p%0d", p), 64'(rvalid1[p]), 64'(pb[p].v));
        if (pa[p].v) begin
          chk($sformatf("err0 p%0d", p), 64'(err0[p]), 64'(pa[p].e));
          if (pa[p].k) chk($sformatf("rdata0 p%0d", p), 64'(rdata0[p]), 64'(pa[p].d));
          if (pa[p].le) begin
            chk($sformatf("lit err0 p%0d", p), 64'(err0[p]), 64'(pa[p].lerr));
            chk($sformatf("lit rdata0 p%0d", p), 64'(rdata0[p]), 64'(pa[p].ld));
          end
        end
        if (pb[p].v) begin
          chk($sformatf("err1 p%0d", p), 64'(err1[p]), 64'(pb[p].e));
          if (pb[p].k) chk($sformatf("rdata1 p%0d", p), 64'(rdata1[p]), 64'(pb[p].d));
          if (pb[p].le) chk($sformatf("lit rdata1 p%0d", p), 64'(rdata1[p]), 64'(pb[p].ld));
        end
      end

      // new responses: reads see memory before this cycle's writes
      for (int p = 0; p < NP; p++) begin
        nr[p].v    = eg[p];
        nr[p].e    = eg[p] & !is_mapped(addr[p]);
        nr[p].d    = 32'd0;
        nr[p].k    = 1'b1;
        nr[p].le   = eg[p] & lit_en[p];
        nr[p].lerr = lit_err[p];
        nr[p].ld   = lit_data[p];
        if (eg[p] && is_mapped(addr[p]) && !we[p]) begin
          nr[p].k = mm.exists(key_of(addr[p]));
          nr[p].d = nr[p].k ? mm[key_of(addr[p])] : 32'd0;
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (eg[p] && is_mapped(addr[p]) && we[p]) begin
          int kk;
          logic [31:0] w;
          kk = key_of(addr[p]);
          if (mm.exists(kk)) begin
            w = mm[kk];
            for (int i = 0; i < 4; i++) if (be[p][i]) w[i*8 +: 8] = wdata[p][i*8 +: 8];
            mm[kk] = w;
          end else if (be[p] == 4'hf) begin
            mm[kk] = wdata[p];
          end
        end
      end
      for (int p = 0; p < NP; p++) begin
        pb[p] = pa[p];
        pa[p] = nr[p];
      end
    end
  end

  task automatic idle_all();
    req = '0; we = '0; be = '0; wdata = '0; addr = '0;
    lit_gnt_en = 1'b0; lit_gnt = '0; lit_en = '0; lit_err = '0;
    lit_data[0] = 32'd0; lit_data[1] = 32'd0;
  endtask

  task automatic drv(input int p, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    req[p] = 1'b1; we[p] = w; addr[p] = a; be[p] = b; wdata[p] = d;
  endtask

  task automatic lit(input int p, input logic e, input logic [31:0] d);
    lit_en[p] = 1'b1; lit_err[p] = e; lit_data[p] = d;
  endtask

  task automatic lgnt(input logic [NP-1:0] g);
    lit_gnt_en = 1'b1; lit_gnt = g;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_mis = 0;
    rst = 1'b0;
    idle_all();
    tick(); tick();
    rst = 1'b1;
    tick();

    // round-robin on bank0: p0,p1,p0,p1 while both hold requests
    for (int c = 0; c < 4; c++) begin
      idle_all();
      drv(0, 1'b1, 32'h0, 4'hf, 32'ha0a0a0a0);
      drv(1, 1'b1, 32'h10, 4'hf, 32'hb1b1b1b1);
      lgnt((c % 2 == 0) ? 2'b01 : 2'b10);
      lit((c % 2 == 0) ? 0 : 1, 1'b0, 32'd0);
      tick();
    end

    // write then read the same word on the next cycle from the other port
    idle_all(); drv(0, 1'b1, 32'h0, 4'hf, 32'hdeadbeef); lit(0, 1'b0, 32'd0); tick();
    idle_all(); drv(1, 1'b0, 32'h0, 4'h0, 32'd0); lit(1, 1'b0, 32'hdeadbeef); tick();

    // different banks are served in the same cycle
    idle_all(); drv(0, 1'b0, 32'h0, 4'h0, 32'd0); drv(1, 1'b1, 32'h4, 4'hf, 32'h0badf00d);
    lgnt(2'b11); lit(0, 1'b0, 32'hdeadbeef); tick();
    idle_all(); drv(0, 1'b0, 32'h4, 4'h0, 32'd0); drv(1, 1'b0, 32'h0, 4'h0, 32'd0);
    lgnt(2'b11); lit(0, 1'b0, 32'h0badf00d); lit(1, 1'b0, 32'hdeadbeef); tick();

    // byte-enable merge, then a be=0 write that must leave the word alone
    idle_all(); drv(0, 1'b1, 32'h8, 4'hf, 32'h11223344); tick();
    idle_all(); drv(0, 1'b1, 32'h8, 4'b0010, 32'h0000ab00); tick();
    idle_all(); drv(0, 1'b0, 32'h8, 4'h0, 32'd0); lit(0, 1'b0, 32'h1122ab44); tick();
    idle_all(); drv(1, 1'b1, 32'h8, 4'h0, 32'hffffffff); lit(1, 1'b0, 32'd0); tick();
    idle_all(); drv(1, 1'b0, 32'h8, 4'h0, 32'd0); lit(1, 1'b0, 32'h1122ab44); tick();

    // unmapped write beside a mapped bank0 read: both granted at once
    idle_all(); drv(0, 1'b1, 32'h2000, 4'hf, 32'hffffffff); drv(1, 1'b0, 32'h10, 4'h0, 32'd0);
    lgnt(2'b11); lit(0, 1'b1, 32'd0); lit(1, 1'b0, 32'hb1b1b1b1); tick();
    idle_all(); drv(0, 1'b0, 32'h0, 4'h0, 32'd0); drv(1, 1'b0, 32'h2000, 4'h0, 32'd0);
    lgnt(2'b11); lit(0, 1'b0, 32'hdeadbeef); lit(1, 1'b1, 32'd0); tick();
    idle_all(); drv(0, 1'b0, 32'hfffffffc, 4'h0, 32'd0); lit(0, 1'b1, 32'd0); tick();

    // last word of the map (bank3, top row)
    idle_all(); drv(0, 1'b1, 32'h1ffc, 4'hf, 32'hcafef00d); tick();
    idle_all(); drv(1, 1'b0, 32'h1ffc, 4'h0, 32'd0); lit(1, 1'b0, 32'hcafef00d); tick();

    // reset with reads in flight; bank0 pointer is left at 1 beforehand
    idle_all(); drv(0, 1'b0, 32'h0, 4'h0, 32'd0); drv(1, 1'b0, 32'h4, 4'h0, 32'd0); tick();
    idle_all(); drv(0, 1'b0, 32'h4, 4'h0, 32'd0); drv(1, 1'b0, 32'h0, 4'h0, 32'd0);
    #1 rst = 1'b0;
    tick();
    idle_all(); tick();
    rst = 1'b1;
    tick(); tick();

    // pointers restarted at 0: p0 wins bank0 first, then p1
    idle_all(); drv(0, 1'b0, 32'h0, 4'h0, 32'd0); drv(1, 1'b0, 32'h10, 4'h0, 32'd0);
    lgnt(2'b01); lit(0, 1'b0, 32'hdeadbeef); tick();
    idle_all(); drv(1, 1'b0, 32'h10, 4'h0, 32'd0);
    lgnt(2'b10); lit(1, 1'b0, 32'hb1b1b1b1); tick();

    idle_all();
    tick(); tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
